cache_way_refill_ctrl: RTL and testbench
========================================

// Module: cache_way_refill_ctrl
// PURPOSE
//  Responder to cache_way hard faults (line misses). Latches the faulting address and picks a
//  victim way round-robin. Reads the victim's tag back through cache_way, writes the old line
//  back if dirty, then requests the line fill from memory. Finally pulses the tag write into
//  cache_way and releases the stall. Sits between cache_way and the memory/DRAM request port.
// PARAMETERS
//  ADDR_W    31  byte-address width; ADDR_W >= OFFSET_W+INDEX_W+TAG_W
//  OFFSET_W   4  line-offset bits (16-byte line)
//  INDEX_W   11  set-index bits, address[OFFSET_W+INDEX_W-1:OFFSET_W] = [14:4]
//  TAG_W     11  tag bits held per way, address[25:15]
// PORTS
//  main_clk            in   1       single clock, all logic rising-edge
//  main_rst_n          in   1       asynchronous active-low reset
//  in_hard_fault       in   1       from cache_way out_hard_fault
//  in_fault_address    in   ADDR_W  target_address presented with the faulting access
//  in_victim_tag       in   TAG_W   from cache_way out_addr_at_in_way_index
//  in_victim_dirty     in   1       dirty flag of the selected victim line (same timing as tag)
//  out_way_index       out  2       to cache_way in_way_index
//  out_tag_write       out  1       to cache_way do_write; 1-cycle pulse
//  out_target_address  out  ADDR_W  address driven to cache_way while refill_busy=1
//  out_busy            out  1       1 = refill in progress; core holds the access
//  out_fault_clear     out  1       1-cycle pulse on completion
//  mem_req             out  1       memory request valid
//  mem_we              out  1       1 = writeback, 0 = fill
//  mem_addr            out  ADDR_W  line-aligned address; low OFFSET_W bits are 0
//  mem_ack             in   1       memory accepts/completes the current request
// BEHAVIOUR
//  Reset (async, main_rst_n=0): state=IDLE and rr_ctr=0. Outputs: out_way_index=0, out_tag_write=0,
//   out_target_address=0, out_busy=0, out_fault_clear=0, mem_req=0, mem_we=0, mem_addr=0.
//   Reset mid-refill aborts: mem_req drops immediately, no tag write occurs.
//  States:
//  - IDLE: in_hard_fault=1 -> latch fault line addr (low OFFSET_W bits forced 0) and victim=rr_ctr;
//    -> VIC_RD. in_hard_fault=0 -> stay in IDLE.
//  - VIC_RD: out_way_index=victim; out_target_address=fault line addr; 1 cycle (tag RAM + output
//    register latency) -> VIC_CAP.
//  - VIC_CAP: capture in_victim_tag and in_victim_dirty. Dirty -> WB_REQ; clean -> FILL_REQ.
//  - WB_REQ: mem_req=1, mem_we=1, mem_addr={fault[ADDR_W-1:26], vic_tag, fault[14:4], 4'b0}.
//    Held stable until mem_ack; in the ack cycle -> FILL_REQ.
//  - FILL_REQ: mem_req=1, mem_we=0, mem_addr=fault line addr; on mem_ack -> TAG_WR.
//  - TAG_WR: out_tag_write=1 for exactly 1 cycle with out_way_index=victim;
//    rr_ctr<=rr_ctr+1 (wraps 3->0) -> DONE.
//  - DONE: out_fault_clear=1 for 1 cycle -> IDLE.
//  out_busy=1 in every state except IDLE, i.e. from the cycle after the fault is seen through DONE.
//  in_hard_fault is ignored outside IDLE. cache_way's was_hard_fault_starting holds the fault
//   asserted across the refill; that is not a new fault.
//  mem_ack while mem_req=0 is ignored. mem_ack in the first request cycle is legal (0-wait memory).
//  Minimum latency, clean victim, 0-wait memory: fault cycle T -> tag write at T+4 -> clear at T+5.
//  rr_ctr advances only on a completed TAG_WR, never on an aborted or reset refill.
//  Outputs are registered (no comb path from inputs). out_way_index holds the last victim in IDLE.
// TESTING
//  1 Reset, in_hard_fault=1 @T, addr=0x0123_4567, dirty=0, mem_ack same cycle as req
//    -> mem_req/we=0 with addr 0x0123_4560; tag_write @T+4 with way 0; fault_clear @T+5.
//  2 Four successive faults -> victims 0,1,2,3, then 0 again (wrap).
//  3 Dirty victim, tag=0x7FF, fault addr 0x0000_1230
//    -> writeback to mem_addr 0x03FF_9230 (mem_we=1) precedes fill to 0x0000_1230 (mem_we=0).
//  4 mem_ack held low 10 cycles -> mem_req and mem_addr stable throughout; single tag_write after ack.
//  5 main_rst_n pulsed low during FILL_REQ -> all outputs 0 asynchronously; next fault uses same rr_ctr.
//  6 in_hard_fault pulses during WB_REQ/FILL_REQ -> ignored; exactly one refill; busy deasserts after DONE.

Source files
------------

// File: rtl/cache_way_refill_ctrl_if.sv
// Handshake bundle between the refill controller, cache_way and the memory request port.
// The master side is the refill controller; the slave side is cache_way plus memory.
interface cache_way_refill_ctrl_if #(
    parameter int ADDR_W = 31,
    parameter int TAG_W  = 11
);
    logic              in_hard_fault;
    logic [ADDR_W-1:0] in_fault_address;
    logic [TAG_W-1:0]  in_victim_tag;
    logic              in_victim_dirty;
    logic [1:0]        out_way_index;
    logic              out_tag_write;
    logic [ADDR_W-1:0] out_target_address;
    logic              out_busy;
    logic              out_fault_clear;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;

    modport master (
        input  in_hard_fault, in_fault_address, in_victim_tag, in_victim_dirty, mem_ack,
        output out_way_index, out_tag_write, out_target_address, out_busy, out_fault_clear,
               mem_req, mem_we, mem_addr
    );

    modport slave (
        output in_hard_fault, in_fault_address, in_victim_tag, in_victim_dirty, mem_ack,
        input  out_way_index, out_tag_write, out_target_address, out_busy, out_fault_clear,
               mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/cache_way_refill_ctrl.sv
// Refill controller for cache_way misses: picks a round-robin victim, writes it back if dirty,
// fills the line from memory, then writes the new tag and releases the stalled access.
module cache_way_refill_ctrl #(
    parameter int ADDR_W   = 31,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 11,
    parameter int TAG_W    = 11
) (
    input logic                      main_clk,
    input logic                      main_rst_n,
    cache_way_refill_ctrl_if.master  bus
);

    localparam int TAG_LSB = OFFSET_W + INDEX_W;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'({OFFSET_W{1'b1}});
    localparam logic [ADDR_W-1:0] TAG_MASK    = ADDR_W'({TAG_W{1'b1}}) << TAG_LSB;

    typedef enum logic [2:0] {
        IDLE,
        VIC_RD,
        VIC_CAP,
        WB_REQ,
        FILL_REQ,
        TAG_WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        way_q, way_d;
    logic              tag_write_q, tag_write_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              busy_q, busy_d;
    logic              clear_q, clear_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fault_line;
    logic [ADDR_W-1:0] wb_addr;

    // The victim's old line lives at the same set with its own tag spliced into the tag field.
    assign fault_line = bus.in_fault_address & ~OFFSET_MASK;
    assign wb_addr    = (target_q & ~TAG_MASK) | (ADDR_W'(bus.in_victim_tag) << TAG_LSB);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        way_d       = way_q;
        tag_write_d = 1'b0;
        target_d    = target_q;
        busy_d      = busy_q;
        clear_d     = 1'b0;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.in_hard_fault) begin
                    target_d = fault_line;
                    way_d    = rr_q;
                    busy_d   = 1'b1;
                    state_d  = VIC_RD;
                end
            end
            VIC_RD: state_d = VIC_CAP;
            VIC_CAP: begin
                req_d = 1'b1;
                if (bus.in_victim_dirty) begin
                    we_d    = 1'b1;
                    addr_d  = wb_addr;
                    state_d = WB_REQ;
                end else begin
                    we_d    = 1'b0;
                    addr_d  = target_q;
                    state_d = FILL_REQ;
                end
            end
            WB_REQ: begin
                if (bus.mem_ack) begin
                    we_d    = 1'b0;
                    addr_d  = target_q;
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (bus.mem_ack) begin
                    req_d       = 1'b0;
                    addr_d      = '0;
                    tag_write_d = 1'b1;
                    state_d     = TAG_WR;
                end
            end
            TAG_WR: begin
                rr_d    = rr_q + 2'd1;
                clear_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d   = 1'b0;
                target_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a register so nothing on the cache or memory side sees a comb input path.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            way_q       <= '0;
            tag_write_q <= 1'b0;
            target_q    <= '0;
            busy_q      <= 1'b0;
            clear_q     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            way_q       <= way_d;
            tag_write_q <= tag_write_d;
            target_q    <= target_d;
            busy_q      <= busy_d;
            clear_q     <= clear_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.out_way_index      = way_q;
    assign bus.out_tag_write      = tag_write_q;
    assign bus.out_target_address = target_q;
    assign bus.out_busy           = busy_q;
    assign bus.out_fault_clear    = clear_q;
    assign bus.mem_req            = req_q;
    assign bus.mem_we             = we_q;
    assign bus.mem_addr           = addr_q;

endmodule

// File: tb/tb_cache_way_refill_ctrl.sv
// Directed bench for cache_way_refill_ctrl: a scoreboard of expected memory handshakes,
// tag writes and fault clears, popped by a monitor as the controller produces them.
module tb_cache_way_refill_ctrl;

    localparam int EV_MEM = 1;
    localparam int EV_TAG = 2;
    localparam int EV_CLR = 3;

    typedef struct {
        int          kind;
        logic [30:0] addr;
        logic        we;
        logic [1:0]  way;
    } exp_t;

    logic main_clk = 1'b0;
    logic main_rst_n;
    int   cyc = 0;
    int   checkCount = 0;
    int   passCount = 0;
    int   tagCount = 0;
    int   lastTagCyc = 0;
    int   lastClrCyc = 0;
    int   faultCyc = 0;
    logic [1:0] rrModel = 2'd0;
    exp_t sb[$];

    cache_way_refill_ctrl_if #(.ADDR_W(31), .TAG_W(11)) bus ();

    cache_way_refill_ctrl #(
        .ADDR_W(31), .OFFSET_W(4), .INDEX_W(11), .TAG_W(11)
    ) dut (
        .main_clk  (main_clk),
        .main_rst_n(main_rst_n),
        .bus       (bus.master)
    );

    always #5 main_clk = ~main_clk;

    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic pushExpected(input int kind, input logic [30:0] addr, input logic we,
                                input logic [1:0] way);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.we   = we;
        e.way  = way;
        sb.push_back(e);
    endtask

    task automatic popAndCheck(input int kind, input logic [30:0] addr, input logic we,
                               input logic [1:0] way);
        exp_t e;
        checkOutput("sbUnderflow", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("eventKind", 64'(kind), 64'(e.kind));
            if (e.kind == EV_MEM && kind == EV_MEM) begin
                checkOutput("memAddr", 64'(addr), 64'(e.addr));
                checkOutput("memWe", 64'(we), 64'(e.we));
            end
            if (e.kind == EV_TAG && kind == EV_TAG) checkOutput("tagWay", 64'(way), 64'(e.way));
        end
    endtask

    // Monitor samples mid-low-phase, after the stimulus block has settled its negedge writes.
    always @(negedge main_clk) begin
        #2;
        if (main_rst_n === 1'b1) begin
            if (bus.mem_req && bus.mem_ack) popAndCheck(EV_MEM, bus.mem_addr, bus.mem_we, 2'd0);
            if (bus.out_tag_write) begin
                tagCount++;
                lastTagCyc = cyc;
                popAndCheck(EV_TAG, 31'd0, 1'b0, bus.out_way_index);
            end
            if (bus.out_fault_clear) begin
                lastClrCyc = cyc;
                popAndCheck(EV_CLR, 31'd0, 1'b0, 2'd0);
            end
        end
    end

    task automatic resetDut();
        @(negedge main_clk);
        main_rst_n = 1'b0;
        repeat (2) @(negedge main_clk);
        main_rst_n = 1'b1;
        rrModel = 2'd0;
    endtask

    task automatic applyStimulus(input logic [30:0] addr, input logic [10:0] tag,
                                 input logic dirty, input bit expectDone);
        logic [30:0] line;
        line = {addr[30:4], 4'h0};
        bus.in_fault_address = addr;
        bus.in_victim_tag    = tag;
        bus.in_victim_dirty  = dirty;
        if (expectDone) begin
            if (dirty) pushExpected(EV_MEM, {addr[30:26], tag, addr[14:4], 4'h0}, 1'b1, 2'd0);
            pushExpected(EV_MEM, line, 1'b0, 2'd0);
            pushExpected(EV_TAG, 31'd0, 1'b0, rrModel);
            pushExpected(EV_CLR, 31'd0, 1'b0, 2'd0);
        end
        @(negedge main_clk);
        bus.in_hard_fault = 1'b1;
        faultCyc = cyc;
        @(negedge main_clk);
        bus.in_hard_fault = 1'b0;
        #1;
        checkOutput("busyAfterFault", 64'(bus.out_busy), 64'd1);
        checkOutput("wayVicRd", 64'(bus.out_way_index), 64'(rrModel));
        checkOutput("targetAddr", 64'(bus.out_target_address), 64'(line));
        if (expectDone) rrModel = rrModel + 2'd1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && bus.out_busy; i++) @(negedge main_clk);
        #3;
        checkOutput("busyDrop", 64'(bus.out_busy), 64'd0);
        checkOutput("sbDrained", 64'(sb.size()), 64'd0);
    endtask

    task automatic waitMemReq();
        for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge main_clk);
        checkOutput("memReqSeen", 64'(bus.mem_req), 64'd1);
    endtask

    initial begin
        logic [30:0] heldAddr;
        int tagsBefore;

        main_rst_n           = 1'b0;
        bus.in_hard_fault    = 1'b0;
        bus.in_fault_address = '0;
        bus.in_victim_tag    = '0;
        bus.in_victim_dirty  = 1'b0;
        bus.mem_ack          = 1'b1;
        repeat (2) @(negedge main_clk);
        checkOutput("rstBusy", 64'(bus.out_busy), 64'd0);
        checkOutput("rstReq", 64'(bus.mem_req), 64'd0);
        checkOutput("rstAddr", 64'(bus.mem_addr), 64'd0);
        checkOutput("rstWay", 64'(bus.out_way_index), 64'd0);
        checkOutput("rstTarget", 64'(bus.out_target_address), 64'd0);
        main_rst_n = 1'b1;

        $display("[TB] clean miss with zero-wait memory");
        applyStimulus(31'h0123_4567, 11'h055, 1'b0, 1'b1);
        waitIdle();
        checkOutput("tagLatency", 64'(lastTagCyc - faultCyc), 64'd4);
        checkOutput("clrLatency", 64'(lastClrCyc - faultCyc), 64'd5);
        checkOutput("wayHeldIdle", 64'(bus.out_way_index), 64'd0);

        $display("[TB] round-robin victims with wrap");
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(31'h0010_0000 + 31'(i * 32'h110), 11'(i + 3), 1'b0, 1'b1);
            waitIdle();
        end

        $display("[TB] dirty victim writeback then fill");
        applyStimulus(31'h0000_1230, 11'h7FF, 1'b1, 1'b1);
        waitIdle();

        $display("[TB] slow memory holds request stable");
        bus.mem_ack = 1'b0;
        tagsBefore = tagCount;
        applyStimulus(31'h3456_789A, 11'h123, 1'b0, 1'b1);
        waitMemReq();
        heldAddr = bus.mem_addr;
        checkOutput("slowFillAddr", 64'(heldAddr), 64'(31'h3456_7890));
        for (int i = 0; i < 10; i++) begin
            @(negedge main_clk);
            #1;
            checkOutput("slowReqHeld", 64'(bus.mem_req), 64'd1);
            checkOutput("slowAddrHeld", 64'(bus.mem_addr), 64'(heldAddr));
        end
        checkOutput("noEarlyTag", 64'(tagCount), 64'(tagsBefore));
        bus.mem_ack = 1'b1;
        waitIdle();
        checkOutput("singleTag", 64'(tagCount), 64'(tagsBefore + 1));

        $display("[TB] fault pulses during refill are ignored");
        bus.mem_ack = 1'b0;
        applyStimulus(31'h1234_5678, 11'h1A5, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge main_clk);
            bus.in_hard_fault = (i % 2 == 0);
        end
        @(negedge main_clk);
        bus.in_hard_fault = 1'b0;
        bus.mem_ack = 1'b1;
        waitIdle();
        for (int i = 0; i < 5; i++) begin
            @(negedge main_clk);
            #1;
            checkOutput("stayIdle", 64'(bus.out_busy), 64'd0);
        end

        $display("[TB] reset during fill aborts");
        bus.mem_ack = 1'b0;
        tagsBefore = tagCount;
        applyStimulus(31'h0765_4321, 11'h0AA, 1'b0, 1'b0);
        waitMemReq();
        checkOutput("abortIsFill", 64'(bus.mem_we), 64'd0);
        #3;
        main_rst_n = 1'b0;
        #1;
        checkOutput("abortReq", 64'(bus.mem_req), 64'd0);
        checkOutput("abortBusy", 64'(bus.out_busy), 64'd0);
        checkOutput("abortAddr", 64'(bus.mem_addr), 64'd0);
        checkOutput("abortTarget", 64'(bus.out_target_address), 64'd0);
        checkOutput("abortTagWr", 64'(bus.out_tag_write), 64'd0);
        @(negedge main_clk);
        main_rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        checkOutput("abortNoTag", 64'(tagCount), 64'(tagsBefore));
        applyStimulus(31'h0765_4321, 11'h0AA, 1'b0, 1'b1);
        waitIdle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
